// File: rtl/ray_dispatch_sched_if.sv
// ray_dispatch_sched_if
//   Pixel result stream from the ray dispatcher to the framebuffer writer.
//   Ports (modport master = dispatcher side):
//     pix_valid  out  pixel result available
//     pix_ready  in   downstream accepts when high together with pix_valid
//     pix_x      out  pixel column (10 b)
//     pix_y      out  pixel row (9 b)
//     pix_color  out  pixel colour (12 b)
interface ray_dispatch_sched_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_color;

  modport master (output pix_valid, pix_x, pix_y, pix_color, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_color, output pix_ready);
endinterface

// File: rtl/ray_dispatch_sched.sv
// ray_dispatch_sched
//   Walks the frame in raster order, builds one primary ray per pixel, presents
//   it to the sphere tracer once per scene object, keeps the nearest hit and
//   emits one colour per pixel over a valid/ready stream.
//   Ports:
//     clk, rst   clock, asynchronous active-low reset
//     start      one-cycle pulse, begins a frame when idle
//     cam_pos    camera {x[27:18], y[17:8], z[7:0]}, sampled at start
//     obj_addr   scene-table read address; obj_data returns one cycle later
//     ray_init   ray origin (latched camera), ray_dir {dx,dy,dz}, ray_obj object word
//     trace_t    hit distance from tracer, 10'h3FF = miss
//     pix        pixel result stream (master side)
//     busy       high from accepted start until done
//     done       one-cycle pulse after the last pixel is accepted
module ray_dispatch_sched #(
  parameter int          H_RES     = 640,
  parameter int          V_RES     = 480,
  parameter int          N_OBJ     = 4,
  parameter int          TRACE_LAT = 52,
  parameter logic [7:0]  SCREEN_Z  = 8'd0,
  parameter logic [11:0] BG_COLOR  = 12'h000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [27:0]                 cam_pos,
  output logic [3:0]                  obj_addr,
  input  logic [47:0]                 obj_data,
  output logic [27:0]                 ray_init,
  output logic [30:0]                 ray_dir,
  output logic [47:0]                 ray_obj,
  input  logic [9:0]                  trace_t,
  ray_dispatch_sched_if.master        pix,
  output logic                        busy,
  output logic                        done
);

  localparam int             CW        = (TRACE_LAT > 1) ? $clog2(TRACE_LAT) : 1;
  localparam logic [CW-1:0]  WAIT_LAST = CW'(TRACE_LAT - 1);
  localparam logic [3:0]     LAST_OBJ  = 4'(N_OBJ - 1);
  localparam logic [9:0]     LAST_X    = 10'(H_RES - 1);
  localparam logic [8:0]     LAST_Y    = 9'(V_RES - 1);
  localparam logic [9:0]     T_MISS    = 10'h3FF;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_CAPTURE, S_EMIT, S_DONE
  } state_t;

  state_t        state_q;
  logic [3:0]    obj_idx_q;
  logic [3:0]    obj_addr_q;
  logic [CW-1:0] wait_cnt_q;
  logic [9:0]    best_t_q;
  logic [11:0]   best_color_q;
  logic [27:0]   ray_init_q;
  logic [30:0]   ray_dir_q;
  logic [47:0]   ray_obj_q;
  logic [9:0]    pix_x_q;
  logic [8:0]    pix_y_q;
  logic          pix_valid_q;
  logic [11:0]   pix_color_q;
  logic          busy_q;
  logic          done_q;

  logic          hit_d;
  logic [11:0]   color_d;
  logic [9:0]    next_x_d;
  logic [8:0]    next_y_d;
  logic          last_pix_d;

  // Ray direction from camera to the pixel on the image plane; every field
  // wraps modulo its own width.
  function automatic logic [30:0] ray_of(input logic [9:0] x, input logic [8:0] y,
                                         input logic [27:0] cam);
    logic [10:0] dx;
    logic [10:0] dy;
    logic [8:0]  dz;
    dx = {1'b0, x} - {1'b0, cam[27:18]};
    dy = {2'b0, y} - {1'b0, cam[17:8]};
    dz = {1'b0, SCREEN_Z} - {1'b0, cam[7:0]};
    return {dx, dy, dz};
  endfunction

  always_comb begin
    // Strict compare: on equal distance the earlier (lower index) object wins.
    hit_d      = (trace_t != T_MISS) && (trace_t < best_t_q);
    color_d    = hit_d ? ray_obj_q[47:36] : best_color_q;
    last_pix_d = (pix_x_q == LAST_X) && (pix_y_q == LAST_Y);
    if (pix_x_q == LAST_X) begin
      next_x_d = '0;
      next_y_d = pix_y_q + 9'd1;
    end else begin
      next_x_d = pix_x_q + 10'd1;
      next_y_d = pix_y_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      obj_idx_q    <= '0;
      obj_addr_q   <= '0;
      wait_cnt_q   <= '0;
      best_t_q     <= T_MISS;
      best_color_q <= BG_COLOR;
      ray_init_q   <= '0;
      ray_dir_q    <= '0;
      ray_obj_q    <= '0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_valid_q  <= 1'b0;
      pix_color_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            ray_init_q   <= cam_pos;
            ray_dir_q    <= ray_of(10'd0, 9'd0, cam_pos);
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            obj_idx_q    <= '0;
            obj_addr_q   <= '0;
            best_t_q     <= T_MISS;
            best_color_q <= BG_COLOR;
            busy_q       <= 1'b1;
            state_q      <= S_FETCH;
          end
        end
        // The address is already set on the way into FETCH, so a registered
        // scene table has its word ready by LOAD.
        S_FETCH: begin
          obj_addr_q <= obj_idx_q;
          state_q    <= S_LOAD;
        end
        S_LOAD: begin
          ray_obj_q  <= obj_data;
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_q <= S_CAPTURE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
          end
        end
        S_CAPTURE: begin
          if (hit_d) begin
            best_t_q     <= trace_t;
            best_color_q <= ray_obj_q[47:36];
          end
          if (obj_idx_q == LAST_OBJ) begin
            pix_color_q <= color_d;
            pix_valid_q <= 1'b1;
            state_q     <= S_EMIT;
          end else begin
            obj_idx_q  <= obj_idx_q + 4'd1;
            obj_addr_q <= obj_idx_q + 4'd1;
            state_q    <= S_FETCH;
          end
        end
        S_EMIT: begin
          if (pix.pix_ready) begin
            pix_valid_q <= 1'b0;
            if (last_pix_d) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              pix_x_q      <= next_x_d;
              pix_y_q      <= next_y_d;
              ray_dir_q    <= ray_of(next_x_d, next_y_d, ray_init_q);
              obj_idx_q    <= '0;
              obj_addr_q   <= '0;
              best_t_q     <= T_MISS;
              best_color_q <= BG_COLOR;
              state_q      <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign obj_addr      = obj_addr_q;
  assign ray_init      = ray_init_q;
  assign ray_dir       = ray_dir_q;
  assign ray_obj       = ray_obj_q;
  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_x     = pix_x_q;
  assign pix.pix_y     = pix_y_q;
  assign pix.pix_color = pix_color_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ray_dispatch_sched.sv
// tb_ray_dispatch_sched
//   Drives frames into ray_dispatch_sched with a registered scene table and a
//   fixed-latency tracer model, and compares every emitted pixel against a
//   nearest-hit reference computed directly from the scene and camera.
module tb_ray_dispatch_sched;
  localparam int          H    = 4;
  localparam int          V    = 3;
  localparam int          NOBJ = 3;
  localparam int          TL   = 6;
  localparam logic [7:0]  SZ   = 8'd0;
  localparam logic [11:0] BG   = 12'hABC;
  localparam int          NPIX = H * V;

  logic        clk;
  logic        rst;
  logic        start;
  logic [27:0] cam_pos;
  logic [3:0]  obj_addr;
  logic [47:0] obj_data;
  logic [27:0] ray_init;
  logic [30:0] ray_dir;
  logic [47:0] ray_obj;
  logic [9:0]  trace_t;
  logic        busy;
  logic        done;

  ray_dispatch_sched_if pix_if ();

  ray_dispatch_sched #(
    .H_RES(H), .V_RES(V), .N_OBJ(NOBJ), .TRACE_LAT(TL), .SCREEN_Z(SZ), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cam_pos(cam_pos),
    .obj_addr(obj_addr), .obj_data(obj_data),
    .ray_init(ray_init), .ray_dir(ray_dir), .ray_obj(ray_obj),
    .trace_t(trace_t), .pix(pix_if), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;

  logic [47:0] obj_tab [16];
  logic [27:0] cam;
  logic        force_miss = 1'b0;
  logic        mon_en = 1'b0;
  logic        rand_ready = 1'b0;
  logic        long_stall = 1'b0;
  int          stall_left = 0;
  int          exp_x = 0;
  int          exp_y = 0;
  int          pix_cnt = 0;
  int          done_cnt = 0;
  logic        stall_prev = 1'b0;
  logic [9:0]  snap_x;
  logic [8:0]  snap_y;
  logic [11:0] snap_c;
  logic [9:0]  pipe [TL];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Tracer stand-in: distance picked from a small table (with repeats, so ties
  // happen) by hashing the object word and ray.
  function automatic logic [9:0] tmodel(input logic [47:0] o, input logic [30:0] d,
                                        input logic [27:0] c);
    logic [9:0] vals [8];
    logic [2:0] s;
    vals = '{10'h3FF, 10'h3FF, 10'd10, 10'd20, 10'd20, 10'd30, 10'd10, 10'd40};
    s = (o[2:0] ^ o[38:36]) + d[2:0] + d[11:9] + d[22:20] + c[2:0];
    return force_miss ? 10'h3FF : vals[s];
  endfunction

  function automatic logic [30:0] ref_dir(input int x, input int y);
    int dx;
    int dy;
    int dz;
    dx = (x - int'(cam[27:18])) & 'h7FF;
    dy = (y - int'(cam[17:8])) & 'h7FF;
    dz = (int'(SZ) - int'(cam[7:0])) & 'h1FF;
    return 31'((dx << 20) | (dy << 9) | dz);
  endfunction

  function automatic logic [11:0] exp_color(input int x, input int y);
    logic [9:0]  bt;
    logic [11:0] bc;
    logic [9:0]  t;
    bt = 10'h3FF;
    bc = BG;
    for (int i = 0; i < NOBJ; i++) begin
      t = tmodel(obj_tab[i], ref_dir(x, y), cam);
      if (t != 10'h3FF && t < bt) begin
        bt = t;
        bc = obj_tab[i][47:36];
      end
    end
    return bc;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scene table with registered read.
  always @(posedge clk) obj_data <= obj_tab[obj_addr];

  // Tracer: result appears TL cycles after the ray inputs change.
  always @(posedge clk) begin
    pipe[0] <= tmodel(ray_obj, ray_dir, ray_init);
    for (int i = 1; i < TL; i++) pipe[i] <= pipe[i-1];
  end
  assign trace_t = pipe[TL-1];

  // Downstream ready: long stall on pixel 2 when requested, else random or always.
  always @(posedge clk) begin
    #1;
    if (long_stall && pix_cnt == 2 && stall_left > 0 && pix_if.pix_valid) begin
      pix_if.pix_ready = 1'b0;
      stall_left--;
    end else if (rand_ready) begin
      pix_if.pix_ready = ($urandom_range(0, 2) != 0);
    end else begin
      pix_if.pix_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (stall_prev) begin
        check("hold_valid", 64'(pix_if.pix_valid), 64'd1);
        check("hold_x", 64'(pix_if.pix_x), 64'(snap_x));
        check("hold_y", 64'(pix_if.pix_y), 64'(snap_y));
        check("hold_color", 64'(pix_if.pix_color), 64'(snap_c));
      end
      if (busy && pix_cnt < NPIX) begin
        check("ray_dir", 64'(ray_dir), 64'(ref_dir(exp_x, exp_y)));
        check("ray_init", 64'(ray_init), 64'(cam));
      end
      if (pix_if.pix_valid && pix_if.pix_ready) begin
        check("pix_x", 64'(pix_if.pix_x), 64'(exp_x));
        check("pix_y", 64'(pix_if.pix_y), 64'(exp_y));
        check("pix_color", 64'(pix_if.pix_color), 64'(exp_color(exp_x, exp_y)));
        $display("pixel (%0d,%0d) color=%03h", pix_if.pix_x, pix_if.pix_y, pix_if.pix_color);
        pix_cnt++;
        exp_x++;
        if (exp_x == H) begin
          exp_x = 0;
          exp_y++;
        end
      end
      stall_prev = pix_if.pix_valid && !pix_if.pix_ready;
      snap_x = pix_if.pix_x;
      snap_y = pix_if.pix_y;
      snap_c = pix_if.pix_color;
      if (done) done_cnt++;
    end
  end

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_obj_addr"}, 64'(obj_addr), 64'd0);
    check({pfx, "_ray_init"}, 64'(ray_init), 64'd0);
    check({pfx, "_ray_dir"}, 64'(ray_dir), 64'd0);
    check({pfx, "_ray_obj"}, 64'(ray_obj), 64'd0);
    check({pfx, "_pix_valid"}, 64'(pix_if.pix_valid), 64'd0);
    check({pfx, "_pix_x"}, 64'(pix_if.pix_x), 64'd0);
    check({pfx, "_pix_y"}, 64'(pix_if.pix_y), 64'd0);
    check({pfx, "_pix_color"}, 64'(pix_if.pix_color), 64'd0);
    check({pfx, "_busy"}, 64'(busy), 64'd0);
    check({pfx, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic start_frame(input logic [27:0] c, input logic rr, input logic ls);
    for (int i = 0; i < 16; i++) obj_tab[i] = 48'({$urandom(), $urandom()});
    cam        = c;
    cam_pos    = c;
    rand_ready = rr;
    long_stall = ls;
    stall_left = 20;
    exp_x      = 0;
    exp_y      = 0;
    pix_cnt    = 0;
    done_cnt   = 0;
    stall_prev = 1'b0;
    mon_en     = 1'b1;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cam_pos = 28'($urandom());
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic finish_frame(input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < 20000) begin
      @(posedge clk);
      n++;
    end
    check("frame_done_in_time", 64'(done_cnt > 0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("pixel_count", 64'(pix_cnt), 64'(NPIX));
    check("busy_low_after", 64'(busy), 64'd0);
    $display("frame %s: pixels=%0d done_pulses=%0d", name, pix_cnt, done_cnt);
    mon_en = 1'b0;
  endtask

  initial begin
    logic [30:0] t3_dir;
    int n;
    rst = 1'b0;
    start = 1'b0;
    cam_pos = '0;
    pix_if.pix_ready = 1'b1;
    for (int i = 0; i < 16; i++) obj_tab[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    rst = 1'b1;

    // Known camera at pixel (0,0), plus a 20-cycle stall on pixel 2.
    start_frame({10'd100, 10'd200, 8'd50}, 1'b0, 1'b1);
    t3_dir = {11'h79C, 11'h738, 9'h1CE};
    check("t3_ray_dir", 64'(ray_dir), 64'(t3_dir));
    finish_frame("known_cam");

    // Random ready; a start pulse with a different camera arrives mid-frame.
    start_frame(28'($urandom()), 1'b1, 1'b0);
    n = 0;
    while (pix_cnt < 5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 cam_pos = 28'($urandom());
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    finish_frame("start_while_busy");

    // Reset in the middle of the wait for pixel 3, then a fresh frame.
    start_frame(28'($urandom()), 1'b0, 1'b0);
    n = 0;
    while (pix_cnt < 3 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_pixel3", 64'(pix_cnt), 64'd3);
    repeat (4) @(posedge clk);
    #1 mon_en = 1'b0;
    rst = 1'b0;
    #1 check_zero_outputs("abort");
    $display("frame abort: reset asserted after %0d pixels", pix_cnt);
    @(posedge clk);
    #1 rst = 1'b1;
    start_frame(28'($urandom()), 1'b1, 1'b0);
    finish_frame("after_abort");

    // Every object misses: background everywhere.
    force_miss = 1'b1;
    start_frame(28'($urandom()), 1'b1, 1'b0);
    finish_frame("all_miss");
    force_miss = 1'b0;

    start_frame(28'($urandom()), 1'b1, 1'b0);
    finish_frame("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
